// File: rtl/adc_offset_calibrator.sv
// adc_offset_calibrator: averages ADC samples to find the zero-input code and subtracts it from the stream
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   ad_valid     in   ad_data qualifier, one sample per high cycle
//   ad_data      in   unsigned ADC sample
//   cal_start    in   single-cycle recalibration request (honoured in IDLE/READY only)
//   cal_busy     out  calibration in progress (SETTLE, ACCUM, CALC)
//   cal_done     out  one-cycle pulse when a new offset is loaded
//   offset_valid out  an offset has been computed since reset
//   offset       out  rounded mean of the averaged samples
//   corr_valid   out  qualifier for corr_data
//   corr_data    out  signed ad_data - offset, one cycle latency
module adc_offset_calibrator #(
    parameter int WIDTH    = 8,
    parameter int AVG_LOG2 = 10,
    parameter int SETTLE   = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ad_valid,
    input  logic [WIDTH-1:0] ad_data,
    input  logic             cal_start,
    output logic             cal_busy,
    output logic             cal_done,
    output logic             offset_valid,
    output logic [WIDTH-1:0] offset,
    output logic             corr_valid,
    output logic [WIDTH:0]   corr_data
);
    localparam int AW = WIDTH + AVG_LOG2;
    // one counter serves both the settle and the averaging phase
    localparam int CW = ($clog2(SETTLE + 1) > AVG_LOG2 + 1) ? $clog2(SETTLE + 1) : AVG_LOG2 + 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] ACC_LAST    = CW'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACCUM, S_CALC, S_READY} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0] offset_q, offset_d;
    logic            offset_valid_q, offset_valid_d;
    logic            cal_done_q, cal_done_d;
    logic            corr_valid_q, corr_valid_d;
    logic [WIDTH:0]  corr_data_q, corr_data_d;
    logic [WIDTH:0]  rnd;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        offset_d       = offset_q;
        offset_valid_d = offset_valid_q;
        cal_done_d     = 1'b0;
        // round half up; the extra bit catches the all-ones + carry case
        rnd            = {1'b0, acc_q[AW-1:AVG_LOG2]} + {{WIDTH{1'b0}}, acc_q[AVG_LOG2-1]};
        corr_valid_d   = ad_valid & offset_valid_q;
        corr_data_d    = {1'b0, ad_data} - {1'b0, offset_q};
        case (state_q)
            S_IDLE, S_READY: begin
                if (cal_start) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (SETTLE == 0) begin
                    state_d = S_ACCUM;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else if (ad_valid) begin
                    state_d = (cnt_q == SETTLE_LAST) ? S_ACCUM : S_SETTLE;
                    cnt_d   = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
                    acc_d   = '0;
                end
            end
            S_ACCUM: begin
                if (ad_valid) begin
                    acc_d   = acc_q + AW'(ad_data);
                    state_d = (cnt_q == ACC_LAST) ? S_CALC : S_ACCUM;
                    cnt_d   = (cnt_q == ACC_LAST) ? '0 : cnt_q + 1'b1;
                end
            end
            S_CALC: begin
                offset_d       = rnd[WIDTH] ? '1 : rnd[WIDTH-1:0];
                offset_valid_d = 1'b1;
                cal_done_d     = 1'b1;
                state_d        = S_READY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_SETTLE;
            cnt_q          <= '0;
            acc_q          <= '0;
            offset_q       <= '0;
            offset_valid_q <= 1'b0;
            cal_done_q     <= 1'b0;
            corr_valid_q   <= 1'b0;
            corr_data_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            offset_q       <= offset_d;
            offset_valid_q <= offset_valid_d;
            cal_done_q     <= cal_done_d;
            corr_valid_q   <= corr_valid_d;
            corr_data_q    <= corr_data_d;
        end
    end

    assign cal_busy     = (state_q == S_SETTLE) || (state_q == S_ACCUM) || (state_q == S_CALC);
    assign cal_done     = cal_done_q;
    assign offset_valid = offset_valid_q;
    assign offset       = offset_q;
    assign corr_valid   = corr_valid_q;
    assign corr_data    = corr_data_q;
endmodule

// File: tb/tb_adc_offset_calibrator.sv
// tb_adc_offset_calibrator: directed checks of calibration timing, rounding, correction and reset
module tb_adc_offset_calibrator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ad_valid = 1'b0;
    logic [7:0] ad_data = '0;
    logic       cal_start = 1'b0;
    logic       cal_busy, cal_done, offset_valid, corr_valid;
    logic [7:0] offset;
    logic [8:0] corr_data;
    int         total = 0;
    int         bad = 0;
    int         cyc;

    adc_offset_calibrator #(.WIDTH(8), .AVG_LOG2(4), .SETTLE(8)) dut (
        .clk(clk), .rst_n(rst_n), .ad_valid(ad_valid), .ad_data(ad_data),
        .cal_start(cal_start), .cal_busy(cal_busy), .cal_done(cal_done),
        .offset_valid(offset_valid), .offset(offset),
        .corr_valid(corr_valid), .corr_data(corr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // settle samples are 7 so a miscounted settle phase shifts the mean
    function automatic logic [7:0] smp(input int mode, input int i);
        int j;
        j = i - 8;
        if (mode == 4) return 8'd120;
        if (i < 8) return 8'd7;
        case (mode)
            1: return (j % 2 == 1) ? 8'd11 : 8'd10;
            2: return (j == 15) ? 8'd11 : 8'd10;
            3: return 8'd255;
            default: return 8'd100;
        endcase
    endfunction

    // feeds samples from the first settle sample; cyc = cycles until cal_done, -1 on timeout
    task automatic run_cal(input int mode, input bit tog, input bit start, output int c);
        int i;
        if (start) begin
            cal_start = 1'b1;
            ad_valid  = 1'b1;
            ad_data   = 8'd120;
            step();
            cal_start = 1'b0;
        end
        i = 0;
        c = -1;
        ad_valid = 1'b1;
        ad_data  = smp(mode, 0);
        for (int k = 1; k <= 200; k++) begin
            step();
            if (ad_valid) i++;
            ad_valid  = tog ? !ad_valid : 1'b1;
            ad_data   = smp(mode, i);
            cal_start = (mode == 4 && k == 5);
            if (cal_done) begin
                c = k;
                break;
            end
        end
        cal_start = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        chk("rst_offset", offset, 0);
        chk("rst_offset_valid", offset_valid, 0);
        chk("rst_cal_done", cal_done, 0);
        chk("rst_corr_valid", corr_valid, 0);
        chk("rst_corr_data", corr_data, 0);
        rst_n = 1'b1;
        chk("busy_after_rst", cal_busy, 1);

        run_cal(0, 1'b0, 1'b0, cyc);
        chk("first_cycles", cyc, 25);
        chk("first_offset", offset, 100);
        chk("first_offset_valid", offset_valid, 1);
        chk("ready_not_busy", cal_busy, 0);
        ad_valid = 1'b0;
        step();
        chk("done_one_cycle", cal_done, 0);

        run_cal(1, 1'b0, 1'b1, cyc);
        chk("alt_cycles", cyc, 25);
        chk("alt_offset", offset, 11);
        run_cal(2, 1'b0, 1'b1, cyc);
        chk("below_half_offset", offset, 10);
        run_cal(1, 1'b1, 1'b1, cyc);
        chk("toggle_cycles", cyc, 48);
        chk("toggle_offset", offset, 11);

        run_cal(3, 1'b0, 1'b1, cyc);
        chk("max_offset", offset, 255);
        ad_valid = 1'b1;
        ad_data  = 8'd0;
        step();
        chk("neg_corr_valid", corr_valid, 1);
        chk("neg_corr_data", corr_data, 9'h101);
        ad_valid = 1'b0;
        step();
        chk("corr_valid_low", corr_valid, 0);

        run_cal(0, 1'b0, 1'b1, cyc);
        chk("base_offset", offset, 100);
        run_cal(4, 1'b0, 1'b1, cyc);
        chk("recal_cycles", cyc, 25);
        chk("recal_old_corr", corr_data, 20);
        chk("recal_offset", offset, 120);
        step();
        chk("recal_new_corr", corr_data, 0);
        chk("recal_corr_valid", corr_valid, 1);

        cal_start = 1'b1;
        ad_valid  = 1'b1;
        ad_data   = 8'd50;
        step();
        cal_start = 1'b0;
        repeat (15) step();
        chk("mid_busy", cal_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_offset", offset, 0);
        chk("mid_rst_offset_valid", offset_valid, 0);
        chk("mid_rst_cal_done", cal_done, 0);
        chk("mid_rst_corr_valid", corr_valid, 0);
        chk("mid_rst_corr_data", corr_data, 0);
        ad_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("mid_rst_busy", cal_busy, 1);
        run_cal(0, 1'b0, 1'b0, cyc);
        chk("after_rst_cycles", cyc, 25);
        chk("after_rst_offset", offset, 100);
        chk("after_rst_offset_valid", offset_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_offset_calibrator.md
ADC_OFFSET_CALIBRATOR -- requirements
Module: adc_offset_calibrator

Interface
REQ-001 SHALL have parameter WIDTH, default 8: ADC sample width, 4..16.
REQ-002 SHALL have parameter AVG_LOG2, default 10: log2 of the number of samples averaged, 1..12.
REQ-003 SHALL have parameter SETTLE, default 1024: number of valid samples discarded before averaging, 0..65535.
REQ-004 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port ad_valid  in  1  ad_data qualifier; one sample per high cycle.
REQ-007 SHALL have port ad_data  in  WIDTH  unsigned ADC sample.
REQ-008 SHALL have port cal_start  in  1  single-cycle request to recalibrate.
REQ-009 SHALL have port cal_busy  out  1  high while state is SETTLE, ACCUM or CALC.
REQ-010 SHALL have port cal_done  out  1  one-cycle pulse when a new offset is loaded.
REQ-011 SHALL have port offset_valid  out  1  level; high once any calibration has completed.
REQ-012 SHALL have port offset  out  WIDTH  rounded mean of the averaged samples (zero-input code).
REQ-013 SHALL have port corr_valid  out  1  qualifier for corr_data.
REQ-014 SHALL have port corr_data  out  WIDTH+1  signed two's-complement ad_data minus offset.

Function
REQ-015 SHALL implement the FSM states IDLE, SETTLE, ACCUM, CALC and READY.
REQ-016 SHALL leave reset in SETTLE, so that calibration starts automatically with no cal_start.
REQ-017 SHALL, in SETTLE, count ad_valid cycles only, and go to ACCUM after SETTLE samples have been discarded; with SETTLE=0, SETTLE SHALL pass straight to ACCUM on the next cycle.
REQ-018 SHALL, in ACCUM, add ad_data into an accumulator of WIDTH+AVG_LOG2 bits on each ad_valid cycle; the accumulator SHALL be cleared on entry to ACCUM.
REQ-019 SHALL go from ACCUM to CALC on the cycle the 2^AVG_LOG2-th sample is accumulated.
REQ-020 SHALL, in CALC (one cycle), set offset = sum >> AVG_LOG2, plus 1 if bit AVG_LOG2-1 of sum is 1 (round half up).
REQ-021 SHALL saturate a rounded offset result of 2^WIDTH to 2^WIDTH-1.
REQ-022 SHALL, on leaving CALC, load offset, pulse cal_done for one cycle, set offset_valid=1 and go to READY.
REQ-023 SHALL, in READY or IDLE, on cal_start=1, go to SETTLE on the next cycle.
REQ-024 SHALL ignore cal_start while cal_busy=1; no restart and no queuing.
REQ-025 SHALL hold the previous offset and offset_valid during a recalibration until CALC completes.
REQ-026 SHALL count no samples and change no state while ad_valid=0, whatever the state.
REQ-027 SHALL register corr_data = {0,ad_data} - {0,offset} with latency 1: corr_valid = ad_valid delayed one cycle, AND offset_valid at the sample cycle.
REQ-028 SHALL make corr_data wide enough that no correction result overflows.
REQ-029 SHALL use the offset loaded in the same cycle as a sample for that sample's correction, on the cycle cal_done is asserted.
REQ-030 SHALL size all counters from the parameters, and no counter SHALL wrap before its terminal count.

Reset
REQ-031 SHALL drive the following on rst_n=0, asynchronously: state=SETTLE, counters=0, accumulator=0, offset=0, offset_valid=0, cal_done=0, corr_valid=0, corr_data=0.
REQ-032 SHALL drive cal_busy=1 from the first cycle after reset release.
REQ-033 SHALL abort a calibration in progress on a reset asserted mid-calibration, and SHALL lose the previous offset.

Verification (WIDTH=8, AVG_LOG2=4, SETTLE=8)
REQ-034 SHALL cover: reset release, ad_valid=1 continuous, ad_data=100 -> cal_done exactly 8+16+1 cycles after the first sample; offset=100; offset_valid=1.
REQ-035 SHALL cover: 16 averaged samples alternating 10/11 (sum=168) -> offset=11 (168/16=10.5, rounded up); 8x10 then 8x10 plus one 11 below half -> offset=10.
REQ-036 SHALL cover: all samples 255 -> offset=255 with no wrap; then ad_data=0 -> corr_data=-255 (9'h101), corr_valid=1.
REQ-037 SHALL cover: ad_valid toggling 1/0 -> completion takes twice the cycles; the result is identical to continuous input.
REQ-038 SHALL cover: offset=100, then cal_start with input 120 -> corr_data uses 100 until cal_done, then 0; a cal_start pulsed mid-calibration has no effect.
REQ-039 SHALL cover: rst_n pulsed during ACCUM -> all outputs at reset values; a new calibration runs from SETTLE.
